// File: rtl/reg_access_pkg.sv
// Shared defaults and FSM state encoding for the register-file access master.
package reg_access_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;
    localparam int LEN_W      = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WRITE  = 3'd1,
        READ   = 3'd2,
        DONE   = 3'd3,
        VERIFY = 3'd4
    } state_t;

endpackage

// File: rtl/reg_access_master.sv
// Burst initiator for the 256x8 register file: turns read/write burst commands into rf_* cycles.
// Define REG_ACCESS_READBACK_EN to check every written beat by reading it back (mismatches raise verify_err).
module reg_access_master
    import reg_access_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    input  logic [DATA_W-1:0] wdata,
    output logic              rdata_valid,
    input  logic              rdata_ready,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_last,
    output logic              done,
    output logic [ADDR_W-1:0] rf_read_address,
    input  logic [DATA_W-1:0] rf_read_data,
    output logic [ADDR_W-1:0] rf_write_address,
    output logic [DATA_W-1:0] rf_write_data,
    output logic              rf_write_enable
`ifdef REG_ACCESS_READBACK_EN
    ,
    output logic              verify_err
`endif
);

    state_t            r_state;
    logic [ADDR_W-1:0] r_cur_addr;
    logic [LEN_W-1:0]  r_remaining;
    logic [DATA_W-1:0] r_rdata;
    logic              r_rdata_valid;
    logic              r_rdata_last;

    logic              w_last_beat;
    logic              w_wr_beat;
    logic              w_rd_fetch;
    logic              w_rd_finish;

`ifdef REG_ACCESS_READBACK_EN
    logic [ADDR_W-1:0] r_verify_addr;
    logic [DATA_W-1:0] r_verify_data;
    logic              r_verify_last;
    logic              r_verify_err;
`endif

    assign w_last_beat = (r_remaining == '0);
    assign w_wr_beat   = (r_state == WRITE) && wdata_valid;

    // Once the final beat sits in the output register nothing more is fetched; it only waits to be consumed.
    assign w_rd_finish = (r_state == READ) && r_rdata_valid && r_rdata_last && rdata_ready;
    assign w_rd_fetch  = (r_state == READ) && !(r_rdata_valid && r_rdata_last)
                         && (!r_rdata_valid || rdata_ready);

    assign cmd_ready        = (r_state == IDLE);
    assign wdata_ready      = (r_state == WRITE);
    assign done             = (r_state == DONE);
    assign rdata_valid      = r_rdata_valid;
    assign rdata            = r_rdata;
    assign rdata_last       = r_rdata_last;
    assign rf_write_enable  = w_wr_beat;
    assign rf_write_address = r_cur_addr;
    assign rf_write_data    = wdata;

`ifdef REG_ACCESS_READBACK_EN
    assign rf_read_address = (r_state == VERIFY) ? r_verify_addr : r_cur_addr;
    assign verify_err      = r_verify_err;
`else
    assign rf_read_address = r_cur_addr;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_cur_addr    <= '0;
            r_remaining   <= '0;
            r_rdata       <= '0;
            r_rdata_valid <= 1'b0;
            r_rdata_last  <= 1'b0;
`ifdef REG_ACCESS_READBACK_EN
            r_verify_addr <= '0;
            r_verify_data <= '0;
            r_verify_last <= 1'b0;
            r_verify_err  <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        r_cur_addr  <= cmd_addr;
                        r_remaining <= cmd_len;
                        r_state     <= cmd_write ? WRITE : READ;
`ifdef REG_ACCESS_READBACK_EN
                        r_verify_err <= 1'b0;
`endif
                    end
                end

                WRITE: begin
                    if (w_wr_beat) begin
                        r_cur_addr  <= r_cur_addr + ADDR_W'(1);
                        r_remaining <= r_remaining - LEN_W'(1);
`ifdef REG_ACCESS_READBACK_EN
                        r_verify_addr <= r_cur_addr;
                        r_verify_data <= wdata;
                        r_verify_last <= w_last_beat;
                        r_state       <= VERIFY;
`else
                        if (w_last_beat) begin
                            r_state <= DONE;
                        end
`endif
                    end
                end

`ifdef REG_ACCESS_READBACK_EN
                // The beat landed on the previous edge, so the combinational read already shows it.
                VERIFY: begin
                    if (rf_read_data != r_verify_data) begin
                        r_verify_err <= 1'b1;
                    end
                    r_state <= r_verify_last ? DONE : WRITE;
                end
`endif

                READ: begin
                    if (w_rd_finish) begin
                        r_rdata_valid <= 1'b0;
                        r_rdata_last  <= 1'b0;
                        r_state       <= DONE;
                    end else if (w_rd_fetch) begin
                        r_rdata       <= rf_read_data;
                        r_rdata_valid <= 1'b1;
                        r_rdata_last  <= w_last_beat;
                        r_cur_addr    <= r_cur_addr + ADDR_W'(1);
                        r_remaining   <= r_remaining - LEN_W'(1);
                    end
                end

                DONE: begin
                    r_state <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_access_master.sv
// Scoreboard bench for reg_access_master with a 256x8 register file model and a shadow memory reference.
// Define REG_ACCESS_READBACK_EN here as well to exercise the write-verify path.
module tb_reg_access_master;

    localparam int TIMEOUT = 2000;
`ifdef REG_ACCESS_READBACK_EN
    localparam int WR_SPAN = 6;
`else
    localparam int WR_SPAN = 3;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_len;
    logic       wdata_valid;
    logic       wdata_ready;
    logic [7:0] wdata;
    logic       rdata_valid;
    logic       rdata_ready;
    logic [7:0] rdata;
    logic       rdata_last;
    logic       done;
    logic [7:0] rf_read_address;
    logic [7:0] rf_read_data;
    logic [7:0] rf_write_address;
    logic [7:0] rf_write_data;
    logic       rf_write_enable;
`ifdef REG_ACCESS_READBACK_EN
    logic       verify_err;
`endif

    logic [7:0]  rfMem [256];
    logic [7:0]  refMem [256];
    logic [7:0]  beatData [256];
    logic        memClear;
    logic        corruptEn;
    logic [7:0]  corruptAddr;
    logic [15:0] wrExpQ [$];
    logic [8:0]  rdExpQ [$];
    logic [15:0] expW;
    logic [8:0]  expR;
    logic        prevStall;
    logic        prevLast;
    logic [7:0]  prevData;
    int          readyMode = 0;
    int          pendingDone = 0;
    int          cycleCnt = 0;
    int          acceptCycle = 0;
    int          wrFirst = -1;
    int          wrLast = -1;
    int          rdFirst = -1;
    int          rdLast = -1;
    int          stallCnt = 0;
    int          nChecks = 0;
    int          nFail = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    reg_access_master #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk              (clk),
        .rst              (rst),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_write        (cmd_write),
        .cmd_addr         (cmd_addr),
        .cmd_len          (cmd_len),
        .wdata_valid      (wdata_valid),
        .wdata_ready      (wdata_ready),
        .wdata            (wdata),
        .rdata_valid      (rdata_valid),
        .rdata_ready      (rdata_ready),
        .rdata            (rdata),
        .rdata_last       (rdata_last),
        .done             (done),
        .rf_read_address  (rf_read_address),
        .rf_read_data     (rf_read_data),
        .rf_write_address (rf_write_address),
        .rf_write_data    (rf_write_data),
        .rf_write_enable  (rf_write_enable)
`ifdef REG_ACCESS_READBACK_EN
        ,
        .verify_err       (verify_err)
`endif
    );

    // Register file: combinational read, write on the edge; can be told to corrupt one address.
    assign rf_read_data = rfMem[rf_read_address];

    always @(posedge clk) begin
        if (memClear) begin
            for (int i = 0; i < 256; i++) rfMem[i] <= 8'h00;
        end else if (rf_write_enable) begin
            rfMem[rf_write_address] <= (corruptEn && rf_write_address == corruptAddr)
                                       ? ~rf_write_data : rf_write_data;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFail++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cycleCnt);
        end
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_cmd_ready"},   32'(cmd_ready), 32'd1);
        checkOutput({tag, "_wdata_ready"}, 32'(wdata_ready), 32'd0);
        checkOutput({tag, "_rdata_valid"}, 32'(rdata_valid), 32'd0);
        checkOutput({tag, "_rdata"},       32'(rdata), 32'd0);
        checkOutput({tag, "_rdata_last"},  32'(rdata_last), 32'd0);
        checkOutput({tag, "_done"},        32'(done), 32'd0);
        checkOutput({tag, "_we"},          32'(rf_write_enable), 32'd0);
        checkOutput({tag, "_wr_addr"},     32'(rf_write_address), 32'd0);
        checkOutput({tag, "_rd_addr"},     32'(rf_read_address), 32'd0);
`ifdef REG_ACCESS_READBACK_EN
        checkOutput({tag, "_verify_err"},  32'(verify_err), 32'd0);
`endif
    endtask

    // Issues one burst. Reads queue their expectations from the shadow memory up front; writes queue each
    // beat as it is offered. abortAfter >= 0 raises rst instead of offering that beat.
    task automatic applyStimulus(input logic isWrite, input logic [7:0] addr, input logic [7:0] len,
                                 input int maxGap, input int abortAfter);
        int         cnt;
        int         beats;
        int         gap;
        logic [7:0] a;
        beats = int'(len) + 1;
        if (!isWrite) begin
            for (int i = 0; i < beats; i++) begin
                rdExpQ.push_back({(i == beats - 1), refMem[(int'(addr) + i) % 256]});
            end
        end
        cmd_valid = 1'b1;
        cmd_write = isWrite;
        cmd_addr  = addr;
        cmd_len   = len;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!cmd_ready && cnt < TIMEOUT);
        checkOutput("cmd_ready_seen", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        cmd_valid   = 1'b0;
        acceptCycle = cycleCnt;
        pendingDone++;
        if (isWrite) begin
            for (int i = 0; i < beats; i++) begin
                if (i == abortAfter) begin
                    rst         = 1'b1;
                    wdata       = beatData[i];
                    wdata_valid = 1'b1;
                    return;
                end
                gap = (maxGap > 0) ? int'($urandom_range(0, maxGap)) : 0;
                if (gap > 0) begin
                    wdata_valid = 1'b0;
                    repeat (gap) @(posedge clk);
                    #1;
                end
                a           = addr + 8'(i);
                wdata_valid = 1'b1;
                wdata       = beatData[i];
                wrExpQ.push_back({a, beatData[i]});
                refMem[a] = beatData[i];
                cnt = 0;
                do begin
                    @(negedge clk);
                    cnt++;
                end while (!wdata_ready && cnt < TIMEOUT);
                checkOutput("wdata_ready_seen", 32'(wdata_ready), 32'd1);
                if (!wdata_ready) begin
                    wdata_valid = 1'b0;
                    return;
                end
                @(posedge clk);
                #1;
            end
            wdata_valid = 1'b0;
        end
    endtask

    task automatic waitDone();
        int cnt;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!done && cnt < TIMEOUT);
        checkOutput("done_seen", 32'(done), 32'd1);
        checkOutput("write_queue_drained", 32'(wrExpQ.size()), 32'd0);
        checkOutput("read_queue_drained", 32'(rdExpQ.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int phase;
        phase = 0;
        rdata_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (readyMode)
                0: rdata_ready = 1'b1;
                1: begin
                    rdata_ready = (phase == 0);
                    phase = (phase + 1) % 3;
                end
                default: rdata_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: pops the scoreboard on every handshake and checks stall stability and done pulses.
    always @(negedge clk) begin
        if (rst) begin
            prevStall = 1'b0;
        end else begin
            if (rf_write_enable) begin
                checkOutput("write_expected", 32'(wrExpQ.size() != 0), 32'd1);
                if (wrExpQ.size() != 0) begin
                    expW = wrExpQ.pop_front();
                    checkOutput("write_beat", 32'({rf_write_address, rf_write_data}), 32'(expW));
                end
                if (wrFirst < 0) wrFirst = cycleCnt;
                wrLast = cycleCnt;
            end
            if (wdata_valid && !wdata_ready) begin
                checkOutput("we_outside_write", 32'(rf_write_enable), 32'd0);
            end
            if (rdata_valid && rdata_ready) begin
                checkOutput("read_expected", 32'(rdExpQ.size() != 0), 32'd1);
                if (rdExpQ.size() != 0) begin
                    expR = rdExpQ.pop_front();
                    checkOutput("read_beat", 32'({rdata_last, rdata}), 32'(expR));
                end
                if (rdFirst < 0) rdFirst = cycleCnt;
                rdLast = cycleCnt;
            end
            if (prevStall) begin
                stallCnt++;
                checkOutput("stall_hold", 32'({rdata_valid, rdata_last, rdata}), 32'({1'b1, prevLast, prevData}));
            end
            prevStall = rdata_valid && !rdata_ready;
            prevLast  = rdata_last;
            prevData  = rdata;
            if (done) begin
                checkOutput("done_expected", 32'(pendingDone > 0), 32'd1);
                if (pendingDone > 0) pendingDone--;
            end
        end
    end

    initial begin
        rst         = 1'b1;
        memClear    = 1'b1;
        cmd_valid   = 1'b0;
        cmd_write   = 1'b0;
        cmd_addr    = 8'h00;
        cmd_len     = 8'h00;
        wdata_valid = 1'b0;
        wdata       = 8'h00;
        corruptEn   = 1'b0;
        corruptAddr = 8'h00;
        for (int i = 0; i < 256; i++) refMem[i] = 8'h00;
        @(posedge clk);
        #1;
        memClear = 1'b0;
        @(negedge clk);
        checkReset("por");
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] directed write 0x20..0x23");
        beatData[0] = 8'hA1; beatData[1] = 8'hB2; beatData[2] = 8'hC3; beatData[3] = 8'hD4;
        wrFirst = -1;
        applyStimulus(1'b1, 8'h20, 8'd3, 0, -1);
        waitDone();
        checkOutput("t1_first_write_latency", 32'(wrFirst - acceptCycle), 32'd0);
        checkOutput("t1_write_span", 32'(wrLast - wrFirst), 32'(WR_SPAN));
`ifdef REG_ACCESS_READBACK_EN
        checkOutput("t1_verify_clean", 32'(verify_err), 32'd0);
`endif

        $display("[TB] directed read 0x20..0x23, ready held high");
        readyMode = 0;
        rdFirst = -1;
        applyStimulus(1'b0, 8'h20, 8'd3, 0, -1);
        waitDone();
        checkOutput("t2_first_read_latency", 32'(rdFirst - acceptCycle), 32'd1);
        checkOutput("t2_read_span", 32'(rdLast - rdFirst), 32'd3);

        $display("[TB] read with stalling consumer");
        readyMode = 1;
        stallCnt = 0;
        applyStimulus(1'b0, 8'h20, 8'd2, 0, -1);
        waitDone();
        checkOutput("t3_stall_seen", 32'(stallCnt > 0), 32'd1);

        $display("[TB] write across address wrap");
        for (int i = 0; i < 4; i++) beatData[i] = 8'(i + 1);
        readyMode = 2;
        applyStimulus(1'b1, 8'hFE, 8'd3, 0, -1);
        waitDone();
        applyStimulus(1'b0, 8'hFE, 8'd3, 0, -1);
        waitDone();

        $display("[TB] randomized bursts");
        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < 16; i++) beatData[i] = 8'($urandom);
            readyMode = int'($urandom_range(0, 2));
            applyStimulus(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom_range(0, 15)), 2, -1);
            waitDone();
        end

        $display("[TB] full 256-beat burst from 0x10");
        for (int i = 0; i < 256; i++) beatData[i] = 8'($urandom);
        applyStimulus(1'b1, 8'h10, 8'd255, 0, -1);
        waitDone();
        readyMode = 0;
        applyStimulus(1'b0, 8'h10, 8'd255, 0, -1);
        waitDone();

        $display("[TB] reset during a write burst");
        for (int i = 0; i < 5; i++) beatData[i] = 8'h70 + 8'(i);
        applyStimulus(1'b1, 8'h60, 8'd4, 0, 2);
        pendingDone = 0;
        @(negedge clk);
        checkReset("abort");
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checkOutput("abort_no_we", 32'(rf_write_enable), 32'd0);
            checkOutput("abort_no_done", 32'(done), 32'd0);
        end
        @(posedge clk);
        #1;
        wdata_valid = 1'b0;
        applyStimulus(1'b0, 8'h60, 8'd4, 0, -1);
        waitDone();

`ifdef REG_ACCESS_READBACK_EN
        $display("[TB] readback mismatch at 0x40");
        for (int i = 0; i < 3; i++) beatData[i] = 8'h90 + 8'(i);
        corruptAddr = 8'h40;
        corruptEn   = 1'b1;
        applyStimulus(1'b1, 8'h3F, 8'd2, 0, -1);
        waitDone();
        corruptEn = 1'b0;
        refMem[8'h40] = ~beatData[1];
        checkOutput("verify_err_set", 32'(verify_err), 32'd1);
        applyStimulus(1'b0, 8'h3F, 8'd2, 0, -1);
        checkOutput("verify_err_cleared", 32'(verify_err), 32'd0);
        waitDone();
`endif

        checkOutput("final_pending_done", 32'(pendingDone), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
